// File: rtl/rns_decompose.sv
// rns_decompose
// Streaming residue-number-system front end. Accepts one LWIDTH-bit unsigned
// operand, reduces it against a runtime-loadable table of PARTS moduli (one
// residue per cycle), then streams the residues out in index order.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_we/idx/q        modulus table write (honoured only while idle)
//   in_valid/ready/data operand input handshake
//   out_valid/ready     residue output handshake
//   out_data/idx/last   residue, its modulus index, last-beat flag
//   busy                transaction in flight
//   err                 sticky zero-modulus flag, cleared only by reset
//
// state     | meaning
// S_IDLE    | waiting for an operand, table writable
// S_COMPUTE | one residue per cycle into r_res[r_cnt]
// S_OUTPUT  | streaming r_res[r_cnt] to the downstream lanes
module rns_decompose #(
    parameter int LWIDTH = 64,
    parameter int SWIDTH = 32,
    parameter int PARTS  = 4,
    localparam int IW    = (PARTS > 1) ? $clog2(PARTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [SWIDTH-1:0] cfg_q,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SWIDTH-1:0] out_data,
    output logic [IW-1:0]     out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam logic [IW-1:0] LAST = IW'(PARTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_cnt;
    logic [LWIDTH-1:0] r_opnd;
    logic [SWIDTH-1:0] r_q   [PARTS];
    logic [SWIDTH-1:0] r_res [PARTS];
    logic              r_err;

    logic [SWIDTH-1:0] w_q_cur;
    logic [LWIDTH-1:0] w_rem;
    logic [SWIDTH-1:0] w_res;
    logic              w_q_zero;
    logic              w_cnt_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_next = S_COMPUTE;
            S_COMPUTE: if (w_cnt_last) w_next = S_OUTPUT;
            S_OUTPUT:  if (out_ready && w_cnt_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Direct remainder; a zero modulus would be undefined, so it is forced
    // to a zero residue and flagged instead.
    assign w_cnt_last = (r_cnt == LAST);
    assign w_q_cur    = r_q[r_cnt];
    assign w_q_zero   = (w_q_cur == '0);
    assign w_rem      = w_q_zero ? '0 : (r_opnd % LWIDTH'(w_q_cur));
    assign w_res      = w_rem[SWIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_opnd <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < PARTS; i++) begin
                r_q[i]   <= SWIDTH'(1);
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opnd <= in_data;
                        r_cnt  <= '0;
                    end
                    // Out-of-range indices only exist for non-power-of-2 PARTS.
                    if (cfg_we && (int'(cfg_idx) < PARTS)) begin
                        r_q[cfg_idx] <= cfg_q;
                    end
                end
                S_COMPUTE: begin
                    r_res[r_cnt] <= w_res;
                    if (w_q_zero) r_err <= 1'b1;
                    r_cnt <= w_cnt_last ? '0 : r_cnt + IW'(1);
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_cnt <= w_cnt_last ? '0 : r_cnt + IW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUTPUT);
    assign out_data  = out_valid ? r_res[r_cnt] : '0;
    assign out_idx   = out_valid ? r_cnt : '0;
    assign out_last  = out_valid && w_cnt_last;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_rns_decompose.sv
// tb_rns_decompose
// Scoreboard bench for rns_decompose: expected beats are queued when an
// operand is accepted and compared against every offered output beat.
module tb_rns_decompose;

    localparam int LW = 64;
    localparam int SW = 32;
    localparam int P  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [SW-1:0] cfg_q;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          err;

    rns_decompose #(.LWIDTH(LW), .SWIDTH(SW), .PARTS(P)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_q(cfg_q),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [SW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         sb[$];
    logic [SW-1:0] mq[P];
    bit            inflight = 0;
    bit            prev_valid = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            fv_cyc = 0;

    bit            pat[7];
    int            pat_len = 0;
    bit            pat_fill = 1;
    int            pat_pos = 0;

    always @(posedge clk) cyc++;

    // out_ready pattern advances one step per cycle that a beat is offered
    always @(posedge clk) begin
        #1;
        if (out_valid && pat_len > 0) begin
            out_ready = (pat_pos < pat_len) ? pat[pat_pos] : pat_fill;
            pat_pos++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", 64'(in_ready), 64'(!inflight));
            chk("busy", 64'(busy), 64'(inflight));
            if (out_valid) begin
                if (!prev_valid) fv_cyc = cyc;
                chk("beat_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    chk("out_idx", 64'(out_idx), 64'(sb[0].idx));
                    chk("out_last", 64'(out_last), 64'(sb[0].last));
                    if (out_ready) begin
                        if (sb[0].last) inflight = 0;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    function automatic logic [SW-1:0] resid(input logic [LW-1:0] d, input logic [SW-1:0] q);
        logic [LW-1:0] r;
        if (q == '0) return '0;
        r = d % LW'(q);
        return r[SW-1:0];
    endfunction

    task automatic wr_q(input int idx, input logic [SW-1:0] v, input bit upd);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_q   = v;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (upd) mq[idx] = v;
    endtask

    task automatic send(input logic [LW-1:0] d);
        bit acc = 0;
        beat_t b;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept", 64'(acc), 64'd1);
        if (acc) begin
            acc_cyc  = cyc;
            inflight = 1;
            for (int p = 0; p < P; p++) begin
                b.idx  = IW'(p);
                b.data = resid(d, mq[p]);
                b.last = (p == P - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && inflight; n++) @(negedge clk);
        chk("drain", 64'(inflight), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        inflight   = 0;
        prev_valid = 0;
        for (int i = 0; i < P; i++) mq[i] = 32'd1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_q     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // basic decomposition and latency
        wr_q(0, 32'd3, 1); wr_q(1, 32'd5, 1); wr_q(2, 32'd7, 1); wr_q(3, 32'd11, 1);
        send(64'd1000);
        drain();
        chk("first_valid_latency", 64'(fv_cyc - acc_cyc), 64'd4);
        chk("err_after_basic", 64'(err), 64'd0);

        // wide moduli, q==1 legal
        wr_q(0, 32'hFFFF_FFFF, 1); wr_q(1, 32'd65537, 1); wr_q(2, 32'd1000, 1); wr_q(3, 32'd1, 1);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        chk("err_after_q1", 64'(err), 64'd0);

        // backpressure pattern 1,0,0,1,0,1,1
        wr_q(0, 32'd3, 1); wr_q(1, 32'd5, 1); wr_q(2, 32'd7, 1); wr_q(3, 32'd11, 1);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pat_pos = 0; pat_fill = 1; pat_len = 7;
        send(64'd1000);
        drain();
        pat_len = 0;
        chk("sb_empty_after_stall", 64'(sb.size()), 64'd0);

        // zero modulus sets sticky err during COMPUTE
        wr_q(2, 32'd0, 1);
        send(64'd42);
        wait_cycles(2);
        chk("err_before_zero_entry", 64'(err), 64'd0);
        wait_cycles(1);
        chk("err_at_zero_entry", 64'(err), 64'd1);
        drain();
        wr_q(2, 32'd7, 1);
        send(64'd42);
        drain();
        chk("err_sticky", 64'(err), 64'd1);

        // table write during OUTPUT is dropped, write in IDLE lands
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pat_pos = 0; pat_fill = 1; pat_len = 3;
        send(64'd500);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        @(posedge clk);
        #1;
        wr_q(1, 32'd99, 0);
        drain();
        pat_len = 0;
        send(64'd500);
        drain();
        wr_q(1, 32'd13, 1);
        send(64'd500);
        drain();

        // reset while beat 1 is stalled
        pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pat_pos = 0; pat_fill = 0; pat_len = 1;
        send(64'd1000);
        for (int n = 0; n < 50 && sb.size() != P - 1; n++) @(negedge clk);
        wait_cycles(2);
        do_reset();
        pat_len = 0;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        send(64'd1000);
        drain();
        chk("err_after_ones", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
